// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: queues predicted conditional branches and flushes on mispredict.
// Optional statistics counters are compiled in with `define BRU_STATS_EN.
module branch_resolve_unit #(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_br_push,
    input  logic [2:0]  i_br_push_cond,
    input  logic        i_br_push_pred_taken,
    input  logic [9:0]  i_br_push_tgt_addr,
    input  logic [9:0]  i_br_push_fall_addr,
    input  logic        i_br_resolve,
    input  logic        i_br_c_flag,
    input  logic        i_br_z_flag,
    output logic        o_br_flush,
    output logic [9:0]  o_br_redirect_addr,
    output logic        o_br_full,
    output logic        o_br_empty,
    output logic        o_br_overflow,
    output logic [15:0] o_br_resolved_cnt,
    output logic [15:0] o_br_miss_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [2:0] COND_BREQ = 3'b010;
    localparam logic [2:0] COND_BRNE = 3'b011;
    localparam logic [2:0] COND_BRCS = 3'b100;
    localparam logic [2:0] COND_BRCC = 3'b101;

    logic [2:0]       r_cond [DEPTH];
    logic             r_pred [DEPTH];
    logic [9:0]       r_tgt  [DEPTH];
    logic [9:0]       r_fall [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_flush;
    logic [9:0]       r_redirect;
    logic             r_overflow;

    logic             w_legal;
    logic             w_full;
    logic             w_empty;
    logic             w_resolve_valid;
    logic             w_actual_taken;
    logic             w_mispredict;
    logic             w_push_req;
    logic             w_push_accept;
    logic             w_push_drop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    always_comb begin
        w_legal = 1'b0;
        case (i_br_push_cond)
            COND_BREQ, COND_BRNE, COND_BRCS, COND_BRCC: w_legal = 1'b1;
            default:                                    w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_actual_taken = 1'b0;
        case (r_cond[r_rd_ptr])
            COND_BREQ: w_actual_taken = i_br_z_flag;
            COND_BRNE: w_actual_taken = ~i_br_z_flag;
            COND_BRCS: w_actual_taken = i_br_c_flag;
            COND_BRCC: w_actual_taken = ~i_br_c_flag;
            default:   w_actual_taken = 1'b0;
        endcase
    end

    // Resolves and pushes seen while a flush is in progress belong to the wrong path.
    assign w_resolve_valid = i_br_resolve & ~r_flush & ~w_empty;
    assign w_mispredict    = w_resolve_valid & (w_actual_taken != r_pred[r_rd_ptr]);
    assign w_push_req      = i_br_push & w_legal & ~r_flush & ~w_mispredict;
    assign w_push_accept   = w_push_req & (~w_full | w_resolve_valid);
    assign w_push_drop     = w_push_req & w_full & ~w_resolve_valid;

    always_ff @(posedge i_clk) begin
        if (w_push_accept) begin
            r_cond[r_wr_ptr] <= i_br_push_cond;
            r_pred[r_wr_ptr] <= i_br_push_pred_taken;
            r_tgt[r_wr_ptr]  <= i_br_push_tgt_addr;
            r_fall[r_wr_ptr] <= i_br_push_fall_addr;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_mispredict) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_accept) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_resolve_valid) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_accept, w_resolve_valid})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flush    <= 1'b0;
            r_redirect <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_flush <= w_mispredict;
            if (w_mispredict) begin
                r_redirect <= w_actual_taken ? r_tgt[r_rd_ptr] : r_fall[r_rd_ptr];
            end
            if (w_push_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef BRU_STATS_EN
    logic [15:0] r_resolved_cnt;
    logic [15:0] r_miss_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_resolved_cnt <= '0;
            r_miss_cnt     <= '0;
        end else begin
            if (w_resolve_valid && (r_resolved_cnt != 16'hFFFF)) begin
                r_resolved_cnt <= r_resolved_cnt + 16'd1;
            end
            if (w_mispredict && (r_miss_cnt != 16'hFFFF)) begin
                r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end

    assign o_br_resolved_cnt = r_resolved_cnt;
    assign o_br_miss_cnt     = r_miss_cnt;
`else
    assign o_br_resolved_cnt = 16'h0000;
    assign o_br_miss_cnt     = 16'h0000;
`endif

    assign o_br_flush         = r_flush;
    assign o_br_redirect_addr = r_redirect;
    assign o_br_full          = w_full;
    assign o_br_empty         = w_empty;
    assign o_br_overflow      = r_overflow;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Table-driven bench for branch_resolve_unit with a queue of expected post-edge results.
// Counter expectations follow BRU_STATS_EN when it is defined for the bench.
module tb_branch_resolve_unit;

    typedef struct {
        logic       push;
        logic [2:0] cond;
        logic       pred;
        logic [9:0] tgt;
        logic [9:0] fall;
        logic       res;
        logic       c;
        logic       z;
        logic       eFlush;
        logic [9:0] eRedir;
        logic       eEmpty;
        logic       eFull;
        logic       eOvf;
        int         eRes;
        int         eMiss;
    } vec_t;

    typedef struct {
        int         idx;
        logic       flush;
        logic [9:0] redir;
        logic       empty;
        logic       full;
        logic       ovf;
        logic [15:0] resCnt;
        logic [15:0] missCnt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        brPush;
    logic [2:0]  brPushCond;
    logic        brPushPred;
    logic [9:0]  brPushTgt;
    logic [9:0]  brPushFall;
    logic        brResolve;
    logic        brC;
    logic        brZ;
    logic        brFlush;
    logic [9:0]  brRedirect;
    logic        brFull;
    logic        brEmpty;
    logic        brOverflow;
    logic [15:0] brResolvedCnt;
    logic [15:0] brMissCnt;

    int checks = 0;
    int errors = 0;
    bit statsOn;

    vec_t vecs[$];
    exp_t scoreboard[$];

    branch_resolve_unit #(.DEPTH(4)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_br_push           (brPush),
        .i_br_push_cond      (brPushCond),
        .i_br_push_pred_taken(brPushPred),
        .i_br_push_tgt_addr  (brPushTgt),
        .i_br_push_fall_addr (brPushFall),
        .i_br_resolve        (brResolve),
        .i_br_c_flag         (brC),
        .i_br_z_flag         (brZ),
        .o_br_flush          (brFlush),
        .o_br_redirect_addr  (brRedirect),
        .o_br_full           (brFull),
        .o_br_empty          (brEmpty),
        .o_br_overflow       (brOverflow),
        .o_br_resolved_cnt   (brResolvedCnt),
        .o_br_miss_cnt       (brMissCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string name, input int idx, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s vec%0d actual=%h required=%h", name, idx, act, req);
        end
    endtask

    task automatic addVec(input logic push, input logic [2:0] cond, input logic pred,
                          input logic [9:0] tgt, input logic [9:0] fall,
                          input logic res, input logic c, input logic z,
                          input logic eFlush, input logic [9:0] eRedir, input logic eEmpty,
                          input logic eFull, input logic eOvf, input int eRes, input int eMiss);
        vec_t v;
        v.push = push; v.cond = cond; v.pred = pred; v.tgt = tgt; v.fall = fall;
        v.res = res; v.c = c; v.z = z;
        v.eFlush = eFlush; v.eRedir = eRedir; v.eEmpty = eEmpty; v.eFull = eFull;
        v.eOvf = eOvf; v.eRes = eRes; v.eMiss = eMiss;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        exp_t e;
        @(negedge clk);
        brPush     = v.push;
        brPushCond = v.cond;
        brPushPred = v.pred;
        brPushTgt  = v.tgt;
        brPushFall = v.fall;
        brResolve  = v.res;
        brC        = v.c;
        brZ        = v.z;
        e.idx     = idx;
        e.flush   = v.eFlush;
        e.redir   = v.eRedir;
        e.empty   = v.eEmpty;
        e.full    = v.eFull;
        e.ovf     = v.eOvf;
        e.resCnt  = statsOn ? 16'(v.eRes) : 16'h0;
        e.missCnt = statsOn ? 16'(v.eMiss) : 16'h0;
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        @(posedge clk);
        #1;
        if (scoreboard.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_empty actual=0 required=1");
        end else begin
            e = scoreboard.pop_front();
            checkVal("flush",    e.idx, 16'(brFlush),       16'(e.flush));
            checkVal("redirect", e.idx, 16'(brRedirect),    16'(e.redir));
            checkVal("empty",    e.idx, 16'(brEmpty),       16'(e.empty));
            checkVal("full",     e.idx, 16'(brFull),        16'(e.full));
            checkVal("overflow", e.idx, 16'(brOverflow),    16'(e.ovf));
            checkVal("resolved", e.idx, brResolvedCnt,      e.resCnt);
            checkVal("miss",     e.idx, brMissCnt,          e.missCnt);
        end
    endtask

    task automatic checkResetState(input int tag);
        checkVal("rst_flush",    tag, 16'(brFlush),    16'h0);
        checkVal("rst_redirect", tag, 16'(brRedirect), 16'h0);
        checkVal("rst_empty",    tag, 16'(brEmpty),    16'h1);
        checkVal("rst_full",     tag, 16'(brFull),     16'h0);
        checkVal("rst_overflow", tag, 16'(brOverflow), 16'h0);
        checkVal("rst_resolved", tag, brResolvedCnt,   16'h0);
        checkVal("rst_miss",     tag, brMissCnt,       16'h0);
    endtask

    initial begin
`ifdef BRU_STATS_EN
        statsOn = 1'b1;
`else
        statsOn = 1'b0;
`endif
        // push cond pred tgt fall res c z | flush redir empty full ovf res miss
        addVec(1, 3'b010, 1, 10'h020, 10'h031, 0, 0, 0,  0, 10'h000, 0, 0, 0, 0, 0); // 0
        addVec(0, 3'b000, 0, 10'h000, 10'h000, 1, 0, 1,  0, 10'h000, 1, 0, 0, 1, 0); // 1 BREQ correct
        addVec(1, 3'b101, 1, 10'h010, 10'h045, 0, 0, 0,  0, 10'h000, 0, 0, 0, 1, 0); // 2
        addVec(0, 3'b000, 0, 10'h000, 10'h000, 1, 1, 0,  1, 10'h045, 1, 0, 0, 2, 1); // 3 BRCC miss
        addVec(0, 3'b000, 0, 10'h000, 10'h000, 0, 0, 0,  0, 10'h045, 1, 0, 0, 2, 1); // 4 one-cycle flush
        addVec(1, 3'b011, 0, 10'h100, 10'h0F1, 0, 0, 0,  0, 10'h045, 0, 0, 0, 2, 1); // 5
        addVec(1, 3'b010, 0, 10'h200, 10'h201, 0, 0, 0,  0, 10'h045, 0, 0, 0, 2, 1); // 6
        addVec(1, 3'b100, 1, 10'h300, 10'h301, 0, 0, 0,  0, 10'h045, 0, 0, 0, 2, 1); // 7
        addVec(1, 3'b010, 1, 10'h3F0, 10'h3F1, 1, 0, 0,  1, 10'h100, 1, 0, 0, 3, 2); // 8 BRNE miss + push
        addVec(1, 3'b010, 1, 10'h3E0, 10'h3E1, 1, 0, 1,  0, 10'h100, 1, 0, 0, 3, 2); // 9 push in flush
        addVec(0, 3'b000, 0, 10'h000, 10'h000, 1, 0, 1,  0, 10'h100, 1, 0, 0, 3, 2); // 10 resolve empty
        addVec(1, 3'b010, 1, 10'h011, 10'h0A1, 0, 0, 0,  0, 10'h100, 0, 0, 0, 3, 2); // 11
        addVec(1, 3'b010, 1, 10'h012, 10'h0A2, 0, 0, 0,  0, 10'h100, 0, 0, 0, 3, 2); // 12
        addVec(1, 3'b010, 1, 10'h013, 10'h0A3, 0, 0, 0,  0, 10'h100, 0, 0, 0, 3, 2); // 13
        addVec(1, 3'b010, 1, 10'h014, 10'h0A4, 0, 0, 0,  0, 10'h100, 0, 1, 0, 3, 2); // 14 full
        addVec(1, 3'b101, 0, 10'h015, 10'h0A5, 0, 0, 0,  0, 10'h100, 0, 1, 1, 3, 2); // 15 overflow
        addVec(1, 3'b011, 0, 10'h055, 10'h056, 1, 0, 1,  0, 10'h100, 0, 1, 1, 4, 2); // 16 push+resolve full
        addVec(0, 3'b000, 0, 10'h000, 10'h000, 1, 0, 1,  0, 10'h100, 0, 0, 1, 5, 2); // 17
        addVec(0, 3'b000, 0, 10'h000, 10'h000, 1, 0, 1,  0, 10'h100, 0, 0, 1, 6, 2); // 18
        addVec(0, 3'b000, 0, 10'h000, 10'h000, 1, 0, 1,  0, 10'h100, 0, 0, 1, 7, 2); // 19
        addVec(0, 3'b000, 0, 10'h000, 10'h000, 1, 0, 1,  0, 10'h100, 1, 0, 1, 8, 2); // 20 BRNE pred0 correct
        addVec(1, 3'b000, 1, 10'h066, 10'h067, 0, 0, 0,  0, 10'h100, 1, 0, 1, 8, 2); // 21 illegal code
        addVec(0, 3'b000, 0, 10'h000, 10'h000, 1, 1, 1,  0, 10'h100, 1, 0, 1, 8, 2); // 22 resolve empty

        rst = 1'b1;
        brPush = 0; brPushCond = 0; brPushPred = 0; brPushTgt = 0; brPushFall = 0;
        brResolve = 0; brC = 0; brZ = 0;
        repeat (2) @(posedge clk);
        #1;
        checkResetState(-1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(i, vecs[i]);
            checkOutput();
        end

        // Mispredict, then reset asserted in the middle of the flush cycle.
        @(negedge clk);
        brPush = 1; brPushCond = 3'b100; brPushPred = 0; brPushTgt = 10'h3AA; brPushFall = 10'h3AB;
        brResolve = 0;
        @(negedge clk);
        brPush = 0; brResolve = 1; brC = 1; brZ = 0;
        @(posedge clk);
        #1;
        checkVal("pre_rst_flush",    100, 16'(brFlush),    16'h1);
        checkVal("pre_rst_redirect", 100, 16'(brRedirect), 16'h3AA);
        #2;
        rst = 1'b1;
        #1;
        checkResetState(101);
        @(negedge clk);
        brResolve = 0;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            checkVal("post_rst_flush", 102 + k, 16'(brFlush), 16'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of in-flight conditional-branch prediction entries (power of two, 2..8).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Port CLK  input  1  rising-edge clock.
REQ-004 Port RST  input  1  asynchronous active-high reset.
REQ-005 Port BR_PUSH  input  1  record one predicted conditional branch this cycle.
REQ-006 Port BR_PUSH_COND  input  3  condition code: 010 BREQ, 011 BRNE, 100 BRCS, 101 BRCC; other codes make the push ignored.
REQ-007 Port BR_PUSH_PRED_TAKEN  input  1  the predictor's taken decision for this branch.
REQ-008 Port BR_PUSH_TGT_ADDR  input  10  branch target address.
REQ-009 Port BR_PUSH_FALL_ADDR  input  10  fall-through address (branch PC+1).
REQ-010 Port BR_RESOLVE  input  1  the oldest recorded branch reaches execute this cycle.
REQ-011 Port BR_C_FLAG  input  1  carry flag valid with BR_RESOLVE.
REQ-012 Port BR_Z_FLAG  input  1  zero flag valid with BR_RESOLVE.
REQ-013 Port BR_FLUSH  output  1  one-cycle mispredict flush/PC-load request.
REQ-014 Port BR_REDIRECT_ADDR  output  10  corrected PC, valid while BR_FLUSH=1.
REQ-015 Port BR_FULL  output  1  DEPTH entries held.
REQ-016 Port BR_EMPTY  output  1  zero entries held.
REQ-017 Port BR_OVERFLOW  output  1  sticky flag: a push was dropped because the queue was full.
REQ-018 Port BR_RESOLVED_CNT  output  16  resolved-branch count (see Configuration).
REQ-019 Port BR_MISS_CNT  output  16  mispredict count (see Configuration).

Function
REQ-020 Entries SHALL be held in a circular FIFO with read/write pointers that wrap modulo DEPTH and an occupancy count of width clog2(DEPTH)+1.
REQ-021 A valid push SHALL be written at the rising edge when BR_PUSH=1, the code is legal, the FIFO is not full, BR_FLUSH=0, and no mispredict is detected at that same edge.
REQ-022 A push while full SHALL be dropped and SHALL set BR_OVERFLOW, which stays set until reset.
REQ-023 Actual outcome: BREQ taken iff Z=1; BRNE iff Z=0; BRCS iff C=1; BRCC iff C=0.
REQ-024 BR_RESOLVE with a non-empty FIFO SHALL pop the oldest entry and compare the actual outcome with PRED_TAKEN.
REQ-025 BR_RESOLVE with an empty FIFO SHALL be ignored: no pop, no flush, no count change.
REQ-026 On a mismatch, at the resolving edge the FIFO SHALL be cleared (pointers and count to 0), and in the following cycle BR_FLUSH=1 for exactly one cycle.
REQ-027 BR_REDIRECT_ADDR SHALL be registered: TGT_ADDR if actually taken, FALL_ADDR if actually not taken; its value is held when BR_FLUSH=0.
REQ-028 On a match, the entry SHALL be popped silently with BR_FLUSH=0.
REQ-029 A simultaneous push and resolve with a correct prediction SHALL occur at the same edge: count unchanged, push accepted even when full.
REQ-030 A push at the same edge as a mispredict, or during a BR_FLUSH=1 cycle, SHALL be discarded as wrong-path (BR_OVERFLOW not set).
REQ-031 BR_RESOLVE during a BR_FLUSH=1 cycle SHALL be ignored.
REQ-032 BR_FULL and BR_EMPTY SHALL be decoded combinationally from the registered count.

Reset
REQ-033 RST=1 SHALL immediately clear pointers, count, BR_FLUSH, BR_REDIRECT_ADDR (0x000), BR_OVERFLOW, and both counters; BR_EMPTY=1 and BR_FULL=0.
REQ-034 Reset asserted mid-flush SHALL deassert BR_FLUSH immediately, and no flush SHALL follow the release of reset.

Configuration
REQ-035 Macro BRU_STATS_EN SHALL compile in the two 16-bit counters: BR_RESOLVED_CNT increments on every non-ignored resolve and BR_MISS_CNT on every mismatch, both saturating at 0xFFFF.
REQ-036 Without BRU_STATS_EN, both counter ports SHALL be present and tied to 0, with no counter registers.

Verification
REQ-037 Push BREQ pred=1 tgt=0x020 fall=0x031; resolve Z=1 -> no BR_FLUSH, BR_EMPTY=1.
REQ-038 Push BRCC pred=1 tgt=0x010 fall=0x045; resolve C=1 -> BR_FLUSH=1 for one cycle next cycle, REDIRECT=0x045, FIFO empty.
REQ-039 Push BRNE pred=0 tgt=0x100 fall=0x0F1, then push two more; resolve Z=0 -> flush, REDIRECT=0x100, all three entries cleared; a push at the resolve edge is discarded.
REQ-040 Fill 4 entries, push a fifth -> dropped, BR_OVERFLOW=1; then push+resolve (correct) in the same cycle -> count stays 4, new entry accepted.
REQ-041 Resolve on empty -> no flush, counters unchanged; assert RST during BR_FLUSH -> BR_FLUSH=0 immediately, REDIRECT=0x000.
REQ-042 With BRU_STATS_EN: 3 resolves, 1 miss -> RESOLVED_CNT=3, MISS_CNT=1; without the macro both read 0.
